// File: rtl/binary_to_bcd_sequential_pkg.sv
// Shared constants, FSM encoding and BCD sizing for the binary-to-BCD converters.
// Exports: BCD_DIGIT_WIDTH, state_t, bcd_digits().
package binary_to_bcd_sequential_pkg;

  localparam int BCD_DIGIT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Decimal digits of 2^w-1 = floor(w*log10(2))+1.
  // 2^w is never a power of ten, so the digit count of 2^w-1 equals that of 2^w.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/binary_to_bcd_sequential_step.sv
// One Double-Dabble step: add 3 to every BCD digit >=5, then shift left by 1.
// Ports: scratch_in (BCD part above binary part), scratch_out (stepped word).
module binary_to_bcd_sequential_step
  import binary_to_bcd_sequential_pkg::*;
#(
  parameter int WIDTH_BINARY = 8,
  parameter int WIDTH_BCD    = bcd_digits(WIDTH_BINARY) * BCD_DIGIT_WIDTH
) (
  input  logic [WIDTH_BCD+WIDTH_BINARY-1:0] scratch_in,
  output logic [WIDTH_BCD+WIDTH_BINARY-1:0] scratch_out
);

  localparam int WS     = WIDTH_BCD + WIDTH_BINARY;
  localparam int DIGITS = WIDTH_BCD / BCD_DIGIT_WIDTH;

  logic [WS-1:0] adj;

  assign adj[WIDTH_BINARY-1:0] = scratch_in[WIDTH_BINARY-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam int LSB = WIDTH_BINARY + BCD_DIGIT_WIDTH * i;
    logic [3:0] d;
    assign d = scratch_in[LSB +: 4];
    assign adj[LSB +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
  end

  assign scratch_out = {adj[WS-2:0], 1'b0};

endmodule

// File: rtl/binary_to_bcd_sequential.sv
// Iterative Double-Dabble binary-to-BCD converter, one step per clock.
// Ports: clock/resetn, input valid/ready/binary, output valid/ready/bcd, busy.
module binary_to_bcd_sequential
  import binary_to_bcd_sequential_pkg::*;
#(
  parameter int WIDTH_BINARY = 8,
  parameter int WIDTH_BCD    = bcd_digits(WIDTH_BINARY) * BCD_DIGIT_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [WIDTH_BINARY-1:0] input_binary,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [WIDTH_BCD-1:0]    output_bcd,
  output logic                    busy
);

  localparam int WS    = WIDTH_BCD + WIDTH_BINARY;
  localparam int CNT_W = $clog2(WIDTH_BINARY + 1);

  state_t            state;
  logic [WS-1:0]     scratch;
  logic [WS-1:0]     scratch_next;
  logic [CNT_W-1:0]  cnt;

  binary_to_bcd_sequential_step #(
    .WIDTH_BINARY(WIDTH_BINARY),
    .WIDTH_BCD   (WIDTH_BCD)
  ) u_step (
    .scratch_in (scratch),
    .scratch_out(scratch_next)
  );

  assign input_ready  = (state == IDLE) |
                        ((state == DONE) & output_ready);
  assign output_valid = (state == DONE);
  assign busy         = (state == CONVERT);
  assign output_bcd   = scratch[WS-1 -: WIDTH_BCD];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (input_valid) begin
            scratch <= {{WIDTH_BCD{1'b0}}, input_binary};
            cnt     <= CNT_W'(WIDTH_BINARY);
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= scratch_next;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= DONE;
        end
        DONE: begin
          if (output_ready) begin
            if (input_valid) begin
              scratch <= {{WIDTH_BCD{1'b0}}, input_binary};
              cnt     <= CNT_W'(WIDTH_BINARY);
              state   <= CONVERT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_sequential.sv
// Directed self-checking bench for binary_to_bcd_sequential.
// Covers 8-bit and 16-bit instances: latency, values, back-to-back, backpressure, reset.
module tb_binary_to_bcd_sequential;

  logic        clock = 1'b0;
  logic        resetn;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  ib8;
  logic [11:0] bcd8;

  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] ib16;
  logic [19:0] bcd16;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  binary_to_bcd_sequential #(.WIDTH_BINARY(8)) dut8 (
    .clock       (clock),
    .resetn      (resetn),
    .input_valid (iv8),
    .input_ready (ir8),
    .input_binary(ib8),
    .output_valid(ov8),
    .output_ready(or8),
    .output_bcd  (bcd8),
    .busy        (busy8)
  );

  binary_to_bcd_sequential #(.WIDTH_BINARY(16), .WIDTH_BCD(20)) dut16 (
    .clock       (clock),
    .resetn      (resetn),
    .input_valid (iv16),
    .input_ready (ir16),
    .input_binary(ib16),
    .output_valid(ov16),
    .output_ready(or16),
    .output_bcd  (bcd16),
    .busy        (busy16)
  );

  // Waits from the negedge after the accepting edge; returns edges until valid.
  task automatic wait_valid8(output int cyc);
    cyc = 0;
    while (!ov8 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic convert8(input logic [7:0] val, input logic [11:0] exp,
                          input string tag);
    int cyc;
    @(negedge clock);
    iv8 = 1'b1; ib8 = val; or8 = 1'b1;
    #1;
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", tag, ir8);
    end
    @(negedge clock);
    iv8 = 1'b0; ib8 = 8'hxx;
    wait_valid8(cyc);
    checks++;
    if (cyc !== 8 || ov8 !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d want 8", tag, cyc);
    end
    checks++;
    if (bcd8 !== exp) begin
      errors++;
      $display("FAIL %s bcd: got %h want %h", tag, bcd8, exp);
    end
    @(negedge clock);
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got v=%b r=%b b=%b want 0 1 0",
               tag, ov8, ir8, busy8);
    end
  endtask

  task automatic convert16(input logic [15:0] val, input logic [19:0] exp,
                           input string tag);
    int cyc;
    @(negedge clock);
    iv16 = 1'b1; ib16 = val; or16 = 1'b1;
    @(negedge clock);
    iv16 = 1'b0;
    cyc = 0;
    while (!ov16 && cyc < 60) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (cyc !== 16 || ov16 !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d want 16", tag, cyc);
    end
    checks++;
    if (bcd16 !== exp) begin
      errors++;
      $display("FAIL %s bcd: got %h want %h", tag, bcd16, exp);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    iv8 = 0; ib8 = 0; or8 = 0;
    iv16 = 0; ib16 = 0; or16 = 0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++;
    if (ov8 !== 0 || ir8 !== 1 || busy8 !== 0 || bcd8 !== 12'h000) begin
      errors++;
      $display("FAIL reset: got v=%b r=%b b=%b bcd=%h want 0 1 0 000",
               ov8, ir8, busy8, bcd8);
    end
  endtask

  task automatic test_values();
    convert8(8'hFF, 12'h255, "ff");
    convert8(8'd0,  12'h000, "zero");
    convert8(8'd99, 12'h099, "d99");
    convert8(8'd100, 12'h100, "d100");
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clock);
    iv8 = 1'b1; ib8 = 8'd7; or8 = 1'b1;
    @(negedge clock);
    ib8 = 8'd128;
    wait_valid8(cyc);
    checks++;
    if (cyc !== 8 || bcd8 !== 12'h007) begin
      errors++;
      $display("FAIL b2b_first: got %0d/%h want 8/007", cyc, bcd8);
    end
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", ir8);
    end
    @(negedge clock);
    checks++;
    if (busy8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reload: got b=%b v=%b want 1 0", busy8, ov8);
    end
    iv8 = 1'b0;
    wait_valid8(cyc);
    checks++;
    if (cyc !== 8 || bcd8 !== 12'h128) begin
      errors++;
      $display("FAIL b2b_second: got %0d/%h want 8/128", cyc, bcd8);
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    @(negedge clock);
    iv8 = 1'b1; ib8 = 8'd42; or8 = 1'b0;
    @(negedge clock);
    iv8 = 1'b0;
    wait_valid8(cyc);
    checks++;
    if (cyc !== 8 || bcd8 !== 12'h042) begin
      errors++;
      $display("FAIL bp_result: got %0d/%h want 8/042", cyc, bcd8);
    end
    iv8 = 1'b1; ib8 = 8'd1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || bcd8 !== 12'h042) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    or8 = 1'b1;
    #1;
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %b want 1", ir8);
    end
    @(negedge clock);
    iv8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: got busy=%b want 1", busy8);
    end
    wait_valid8(cyc);
    checks++;
    if (cyc !== 8 || bcd8 !== 12'h001) begin
      errors++;
      $display("FAIL bp_next: got %0d/%h want 8/001", cyc, bcd8);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    iv8 = 1'b1; ib8 = 8'd200; or8 = 1'b1;
    @(negedge clock);
    iv8 = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++;
    if (ov8 !== 0 || busy8 !== 0 || bcd8 !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset: got v=%b b=%b bcd=%h want 0 0 000",
               ov8, busy8, bcd8);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got r=%b v=%b want 1 0", ir8, ov8);
    end
    convert8(8'd13, 12'h013, "after_reset");
  endtask

  task automatic test_wide();
    convert16(16'hFFFF, 20'h65535, "w_ffff");
    convert16(16'd10000, 20'h10000, "w_10000");
  endtask

  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
